// File: rtl/leaf_uplink_arbiter_if.sv
// Groups the four node ingress lanes and the single spine egress lane of the leaf uplink arbiter.
// The slave modport is the arbiter's view; the master modport is the node/spine side.
interface leaf_uplink_arbiter_if #(
    parameter int DWIDTH = 16
);
    logic [4*DWIDTH-1:0] node_in_data;
    logic [3:0]          node_in_valid;
    logic [3:0]          node_in_full;
    logic [DWIDTH-1:0]   spine_out_data;
    logic                spine_out_valid;
    logic                spine_credit_return;
    logic [7:0]          drop_count;

    modport master (
        output node_in_data,
        output node_in_valid,
        output spine_credit_return,
        input  node_in_full,
        input  spine_out_data,
        input  spine_out_valid,
        input  drop_count
    );

    modport slave (
        input  node_in_data,
        input  node_in_valid,
        input  spine_credit_return,
        output node_in_full,
        output spine_out_data,
        output spine_out_valid,
        output drop_count
    );
endinterface

// File: rtl/leaf_uplink_arbiter.sv
// Four-node leaf uplink: per-node ingress FIFOs, credit-gated round-robin onto one spine port.
// Flits are forwarded untouched; overflow on a full FIFO is dropped and counted (saturating).
module leaf_uplink_arbiter #(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    leaf_uplink_arbiter_if.slave  bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] CREDITS_C = CRED_W'(CREDITS);

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    logic [DWIDTH-1:0] mem_r [4][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r [4];
    logic [PTR_W-1:0]  rd_ptr_r [4];
    logic [CNT_W-1:0]  count_r [4];
    logic [CRED_W-1:0] credit_cnt_r;
    logic [1:0]        last_grant_r;
    logic [3:0]        full_r;
    logic [DWIDTH-1:0] out_data_r;
    logic              out_valid_r;
    logic [7:0]        drop_count_r;

    logic [3:0]        push_s;
    logic [3:0]        drop_s;
    logic [3:0]        pop_s;
    logic [3:0]        nonempty_s;
    logic [CNT_W-1:0]  count_next_s [4];
    logic              grant_s;
    logic [1:0]        grant_idx_s;
    logic [1:0]        rr_idx_s;
    logic [8:0]        drop_sum_s;

    // Full is judged on the registered count, so a same-cycle pop never rescues an arriving flit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nonempty_s[i]   = (count_r[i] != {CNT_W{1'b0}});
            push_s[i]       = bus.node_in_valid[i] && (count_r[i] != DEPTH_C);
            drop_s[i]       = bus.node_in_valid[i] && (count_r[i] == DEPTH_C);
            pop_s[i]        = grant_s && (grant_idx_s == 2'(i));
            count_next_s[i] = count_r[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
        end
        drop_sum_s = {1'b0, drop_count_r} + {6'd0, popcount4(drop_s)};
    end

    // Round-robin pick: offsets scanned from far to near so the nearest successor of last_grant wins.
    always_comb begin
        grant_idx_s = 2'd0;
        rr_idx_s    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            rr_idx_s    = last_grant_r + 2'(k);
            grant_idx_s = nonempty_s[rr_idx_s] ? rr_idx_s : grant_idx_s;
        end
        grant_s = (|nonempty_s) && (credit_cnt_r != {CRED_W{1'b0}});
    end

    // Flit storage; slots are only read inside their valid window, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= bus.node_in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // FIFO pointers, occupancy and the registered full flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
                count_r[i]  <= {CNT_W{1'b0}};
            end
            full_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                count_r[i] <= count_next_s[i];
                full_r[i]  <= (count_next_s[i] == DEPTH_C);
            end
        end
    end

    // Spine output register, grant pointer, credit counter and drop statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r   <= {DWIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            last_grant_r <= 2'd3;
            credit_cnt_r <= CREDITS_C;
            drop_count_r <= 8'd0;
        end else begin
            if (grant_s) begin
                out_data_r   <= mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
                out_valid_r  <= 1'b1;
                last_grant_r <= grant_idx_s;
            end else begin
                out_valid_r  <= 1'b0;
            end

            // A return arriving while already at the full allotment is discarded.
            case ({grant_s, bus.spine_credit_return})
                2'b10:   credit_cnt_r <= credit_cnt_r - CRED_W'(1);
                2'b01:   credit_cnt_r <= (credit_cnt_r == CREDITS_C) ? credit_cnt_r
                                                                     : credit_cnt_r + CRED_W'(1);
                default: credit_cnt_r <= credit_cnt_r;
            endcase

            drop_count_r <= (drop_sum_s > 9'd255) ? 8'hFF : drop_sum_s[7:0];
        end
    end

    assign bus.node_in_full    = full_r;
    assign bus.spine_out_data  = out_data_r;
    assign bus.spine_out_valid = out_valid_r;
    assign bus.drop_count      = drop_count_r;
endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// Directed and randomized bench for leaf_uplink_arbiter against a queue-based reference model
// that applies the arbitration, credit and drop rules flit by flit.
module tb_leaf_uplink_arbiter;
    localparam int DW = 16;
    localparam int FD = 4;
    localparam int CR = 8;

    logic clk;
    logic reset;

    leaf_uplink_arbiter_if #(.DWIDTH(DW)) bus ();

    leaf_uplink_arbiter #(.DWIDTH(DW), .FIFO_DEPTH(FD), .CREDITS(CR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [4][$];
    int            m_credit;
    int            m_last;
    int            m_drops;
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            obs_emit;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_credit = CR;
        m_last   = 3;
        m_drops  = 0;
        m_valid  = 1'b0;
        m_data   = '0;
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] exp_full;
        for (int i = 0; i < 4; i++) exp_full[i] = (mq[i].size() == FD);
        check({tag, ".valid"},  64'(bus.spine_out_valid), 64'(m_valid));
        check({tag, ".data"},   64'(bus.spine_out_data),  64'(m_data));
        check({tag, ".full"},   64'(bus.node_in_full),    64'(exp_full));
        check({tag, ".drops"},  64'(bus.drop_count),      64'(m_drops));
        check({tag, ".credit"}, 64'(dut.credit_cnt_r),    64'(m_credit));
    endtask

    // One clock: drive inputs, advance the model by the same edge, then compare after the edge.
    task automatic step(input string tag, input logic [3:0] v, input logic [63:0] d, input logic cr);
        int  sz [4];
        bit  g;
        int  gi;
        bus.node_in_valid       = v;
        bus.node_in_data        = d;
        bus.spine_credit_return = cr;
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        g  = 1'b0;
        gi = 0;
        if (m_credit > 0) begin
            for (int k = 1; k <= 4; k++) begin
                int n;
                n = (m_last + k) % 4;
                if (!g && sz[n] > 0) begin
                    g  = 1'b1;
                    gi = n;
                end
            end
        end
        if (g) begin
            m_data = mq[gi].pop_front();
            m_last = gi;
        end
        m_valid = g;
        if (g && !cr) m_credit--;
        else if (cr && !g && m_credit < CR) m_credit++;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                if (sz[i] < FD) mq[i].push_back(d[i*DW +: DW]);
                else m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
            end
        end
        @(posedge clk);
        #1;
        obs_emit += int'(bus.spine_out_valid);
        compare_all(tag);
    endtask

    task automatic apply_reset();
        bus.node_in_valid       = 4'b0000;
        bus.node_in_data        = 64'h0;
        bus.spine_credit_return = 1'b0;
        reset = 1'b1;
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;
        step("post_reset", 4'b0000, 64'h0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] exp4 [4];
        int crp;

        obs_emit = 0;
        reset    = 1'b1;
        bus.node_in_valid       = 4'b0000;
        bus.node_in_data        = 64'h0;
        bus.spine_credit_return = 1'b0;
        model_reset();

        // Reset values observed while reset is held
        #2;
        check("rst.valid",  64'(bus.spine_out_valid), 64'd0);
        check("rst.data",   64'(bus.spine_out_data),  64'd0);
        check("rst.full",   64'(bus.node_in_full),    64'd0);
        check("rst.drops",  64'(bus.drop_count),      64'd0);
        check("rst.credit", 64'(dut.credit_cnt_r),    64'd8);
        @(negedge clk);
        reset = 1'b0;
        step("idle0", 4'b0000, 64'h0, 1'b0);

        // Single flit on node 2: visible after the second edge, one credit consumed
        step("s1.push", 4'b0100, 64'h0000_1234_0000_0000, 1'b0);
        check("s1.no_early_valid", 64'(bus.spine_out_valid), 64'd0);
        step("s1.out", 4'b0000, 64'h0, 1'b0);
        check("s1.valid",  64'(bus.spine_out_valid), 64'd1);
        check("s1.data",   64'(bus.spine_out_data),  64'h1234);
        check("s1.credit", 64'(dut.credit_cnt_r),    64'd7);
        step("s1.after", 4'b0000, 64'h0, 1'b0);
        check("s1.one_cycle", 64'(bus.spine_out_valid), 64'd0);

        // All four nodes at once: first grant to node 0, then 1, 2, 3
        apply_reset();
        exp4[0] = 16'hA000; exp4[1] = 16'hB001; exp4[2] = 16'hC002; exp4[3] = 16'hD003;
        step("s2.push", 4'b1111, 64'hD003_C002_B001_A000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("s2.drain", 4'b0000, 64'h0, 1'b0);
            check("s2.order_valid", 64'(bus.spine_out_valid), 64'd1);
            check("s2.order_data",  64'(bus.spine_out_data),  64'(exp4[i]));
        end

        // Nine flits on node 0 with no returns: eight leave, the ninth waits for a credit
        apply_reset();
        obs_emit = 0;
        for (int k = 0; k < 9; k++) step("s3.push", 4'b0001, 64'(16'h0100 + k), 1'b0);
        for (int k = 0; k < 4; k++) step("s3.idle", 4'b0000, 64'h0, 1'b0);
        check("s3.emitted", 64'(obs_emit), 64'd8);
        check("s3.credit0", 64'(dut.credit_cnt_r), 64'd0);
        step("s3.return", 4'b0000, 64'h0, 1'b1);
        step("s3.ninth", 4'b0000, 64'h0, 1'b0);
        check("s3.ninth_valid", 64'(bus.spine_out_valid), 64'd1);
        check("s3.ninth_data",  64'(bus.spine_out_data),  64'h0108);

        // Six back-to-back flits on node 1 with no credit: four kept, two dropped
        for (int k = 0; k < 6; k++) step("s4.push", 4'b0010, 64'(32'(16'h2000 + k)) << 16, 1'b0);
        check("s4.full1", 64'(bus.node_in_full[1]), 64'd1);
        check("s4.drops", 64'(bus.drop_count),      64'd2);

        // Grant plus return at credit 3 leaves it at 3; a return at full credit is ignored
        apply_reset();
        for (int k = 0; k < 6; k++) step("s5.push", 4'b1000, 64'(16'h3000 + k) << 48, 1'b0);
        check("s5.credit_pre", 64'(dut.credit_cnt_r), 64'd3);
        step("s5.both", 4'b0000, 64'h0, 1'b1);
        check("s5.credit_same", 64'(dut.credit_cnt_r),    64'd3);
        check("s5.granted",     64'(bus.spine_out_valid), 64'd1);
        apply_reset();
        step("s5.ovf", 4'b0000, 64'h0, 1'b1);
        check("s5.credit_cap", 64'(dut.credit_cnt_r), 64'd8);

        // Mid-operation reset with three flits buffered and one in flight
        apply_reset();
        step("s6.push", 4'b1111, 64'h4444_3333_2222_1111, 1'b0);
        step("s6.first", 4'b0000, 64'h0, 1'b0);
        check("s6.inflight", 64'(bus.spine_out_valid), 64'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check("s6.valid0",  64'(bus.spine_out_valid), 64'd0);
        check("s6.data0",   64'(bus.spine_out_data),  64'd0);
        check("s6.credit8", 64'(dut.credit_cnt_r),    64'd8);
        @(negedge clk);
        reset = 1'b0;
        obs_emit = 0;
        for (int k = 0; k < 6; k++) step("s6.quiet", 4'b0000, 64'h0, 1'b0);
        check("s6.no_stale", 64'(obs_emit), 64'd0);

        // Randomized traffic with varying credit-return pressure
        apply_reset();
        for (int blk = 0; blk < 8; blk++) begin
            crp = (blk % 4) * 30 + 5;
            for (int k = 0; k < 100; k++) begin
                step("rand",
                     4'($urandom_range(0, 15)),
                     {$urandom, $urandom},
                     ($urandom_range(0, 99) < crp));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
